// File: rtl/serial_add_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : serial_add_ctrl
//  Description : Sequencer for an external bit-serial adder. Latches the
//                operands, strobes load/shift, captures sum and carry-out,
//                and presents them on a valid/ready result port.
//  Revision    : 1.0  initial release
// ============================================================================
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             op_cin,
    output logic             busy,
    output logic             result_valid,
    input  logic             result_ready,
    output logic [WIDTH-1:0] result_sum,
    output logic             result_cout,
    output logic             add_load,
    output logic             add_rst_shift,
    output logic             add_rst_ff,
    output logic             add_sipo_load,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    output logic             add_cin,
    input  logic [WIDTH-1:0] add_sum,
    input  logic             add_cout
);

    localparam int c_CNT_W = $clog2(WIDTH) + 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(WIDTH - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    localparam logic [2:0] c_ST_IDLE    = 3'd0;
    localparam logic [2:0] c_ST_LOAD    = 3'd1;
    localparam logic [2:0] c_ST_SHIFT   = 3'd2;
    localparam logic [2:0] c_ST_CAPTURE = 3'd3;
    localparam logic [2:0] c_ST_DONE    = 3'd4;

    logic [2:0]         r_state;
    logic [2:0]         w_next_state;
    logic [c_CNT_W-1:0] r_count;
    logic               r_carry;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic               r_cin;
    logic [WIDTH-1:0]   r_sum;
    logic               r_cout;
    logic               w_accept;
    logic               w_last_shift;

    assign w_accept     = (r_state == c_ST_IDLE) && start;
    assign w_last_shift = (r_state == c_ST_SHIFT) && (r_count == c_CNT_LAST);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (start) begin
                    w_next_state = c_ST_LOAD;
                end
            end
            c_ST_LOAD: begin
                w_next_state = c_ST_SHIFT;
            end
            c_ST_SHIFT: begin
                if (r_count == c_CNT_LAST) begin
                    w_next_state = c_ST_CAPTURE;
                end
            end
            c_ST_CAPTURE: begin
                w_next_state = c_ST_DONE;
            end
            c_ST_DONE: begin
                // Always return through IDLE so a start seen here is dropped.
                if (result_ready) begin
                    w_next_state = c_ST_IDLE;
                end
            end
            default: begin
                w_next_state = c_ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode (pure function of the state register)
    // ------------------------------------------------------------------
    always_comb begin
        busy          = 1'b0;
        result_valid  = 1'b0;
        add_load      = 1'b0;
        add_rst_ff    = 1'b0;
        add_rst_shift = 1'b0;
        add_sipo_load = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                add_rst_shift = 1'b1;
            end
            c_ST_LOAD: begin
                busy       = 1'b1;
                add_load   = 1'b1;
                add_rst_ff = 1'b1;
            end
            c_ST_SHIFT: begin
                busy          = 1'b1;
                add_sipo_load = 1'b1;
            end
            c_ST_CAPTURE: begin
                busy = 1'b1;
            end
            c_ST_DONE: begin
                result_valid = 1'b1;
            end
            default: begin
                add_rst_shift = 1'b1;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Operand latch, shift counter and result capture
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_cin   <= 1'b0;
            r_count <= '0;
            r_carry <= 1'b0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_a   <= op_a;
                r_b   <= op_b;
                r_cin <= op_cin;
            end
            if (r_state == c_ST_LOAD) begin
                r_count <= '0;
            end else if (r_state == c_ST_SHIFT) begin
                r_count <= r_count + c_CNT_ONE;
            end
            // The adder's carry-out is that of the bit being added, so the
            // final carry is only visible during the last shift cycle.
            if (w_last_shift) begin
                r_carry <= add_cout;
            end
            if (r_state == c_ST_CAPTURE) begin
                r_sum  <= add_sum;
                r_cout <= r_carry;
            end
        end
    end

    assign add_a       = r_a;
    assign add_b       = r_b;
    assign add_cin     = r_cin;
    assign result_sum  = r_sum;
    assign result_cout = r_cout;

`ifndef SYNTHESIS
    a_busy_valid_excl : assert property (@(posedge clk) disable iff (!rst_n)
        !(busy && result_valid));

    a_count_in_range : assert property (@(posedge clk) disable iff (!rst_n)
        (r_state == c_ST_SHIFT) |-> (r_count < c_CNT_W'(WIDTH)));

    a_result_hold : assert property (@(posedge clk) disable iff (!rst_n)
        (result_valid && !result_ready) |=>
            (result_valid && $stable(result_sum) && $stable(result_cout)));

    a_state_legal : assert property (@(posedge clk) disable iff (!rst_n)
        (r_state <= c_ST_DONE));
`endif

endmodule
`default_nettype wire

// File: tb/tb_serial_add_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_add_ctrl
//  Description : Directed bench for serial_add_ctrl with a bit-serial adder
//                model driven by the controller's strobes.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_serial_add_ctrl;

    localparam int WIDTH = 8;

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             cin;
        logic [WIDTH-1:0] sum;
        logic             cout;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             start = 1'b0;
    logic [WIDTH-1:0] op_a = '0;
    logic [WIDTH-1:0] op_b = '0;
    logic             op_cin = 1'b0;
    logic             result_ready = 1'b0;
    logic             busy, result_valid, result_cout;
    logic [WIDTH-1:0] result_sum;
    logic             add_load, add_rst_shift, add_rst_ff, add_sipo_load;
    logic [WIDTH-1:0] add_a, add_b;
    logic             add_cin;
    logic [WIDTH-1:0] add_sum;
    logic             add_cout;

    int n_pass  = 0;
    int n_total = 0;

    serial_add_ctrl #(.WIDTH(WIDTH)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .op_a          (op_a),
        .op_b          (op_b),
        .op_cin        (op_cin),
        .busy          (busy),
        .result_valid  (result_valid),
        .result_ready  (result_ready),
        .result_sum    (result_sum),
        .result_cout   (result_cout),
        .add_load      (add_load),
        .add_rst_shift (add_rst_shift),
        .add_rst_ff    (add_rst_ff),
        .add_sipo_load (add_sipo_load),
        .add_a         (add_a),
        .add_b         (add_b),
        .add_cin       (add_cin),
        .add_sum       (add_sum),
        .add_cout      (add_cout)
    );

    always #5 clk = ~clk;

    // Bit-serial adder: LSB-first operand shifters, carry flop, sum SIPO.
    logic [WIDTH-1:0] m_sa = '0;
    logic [WIDTH-1:0] m_sb = '0;
    logic [WIDTH-1:0] m_sum = '0;
    logic             m_c = 1'b0;
    logic             m_bit;

    assign m_bit    = m_sa[0] ^ m_sb[0] ^ m_c;
    assign add_cout = (m_sa[0] & m_sb[0]) | (m_c & (m_sa[0] ^ m_sb[0]));
    assign add_sum  = m_sum;

    always @(posedge clk) begin
        if (add_rst_shift) begin
            m_sa  <= '0;
            m_sb  <= '0;
            m_sum <= '0;
        end else begin
            if (add_load) begin
                m_sa <= add_a;
                m_sb <= add_b;
            end
            if (add_sipo_load) begin
                m_sa  <= m_sa >> 1;
                m_sb  <= m_sb >> 1;
                m_sum <= {m_bit, m_sum[WIDTH-1:1]};
                m_c   <= add_cout;
            end
        end
        if (add_rst_ff) begin
            m_c <= add_cin;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_busy"},      32'(busy),          32'd0);
        chk({tag, "_valid"},     32'(result_valid),  32'd0);
        chk({tag, "_sum"},       32'(result_sum),    32'd0);
        chk({tag, "_cout"},      32'(result_cout),   32'd0);
        chk({tag, "_load"},      32'(add_load),      32'd0);
        chk({tag, "_rst_ff"},    32'(add_rst_ff),    32'd0);
        chk({tag, "_sipo"},      32'(add_sipo_load), 32'd0);
        chk({tag, "_rst_shift"}, 32'(add_rst_shift), 32'd1);
        chk({tag, "_add_a"},     32'(add_a),         32'd0);
        chk({tag, "_add_b"},     32'(add_b),         32'd0);
        chk({tag, "_add_cin"},   32'(add_cin),       32'd0);
    endtask

    // Issues one operation and waits for result_valid; leaves the result pending.
    task automatic run_op(input vec_t v, input bit inject);
        int   edges = 0;
        int   n_load = 0;
        int   n_rstff = 0;
        int   n_sipo = 0;
        int   sipo_runs = 0;
        int   busy_low = 0;
        logic prev_sipo = 1'b0;
        start  = 1'b1;
        op_a   = v.a;
        op_b   = v.b;
        op_cin = v.cin;
        @(posedge clk);
        #1;
        start = 1'b0;
        op_a  = ~v.a;
        op_b  = ~v.b;
        while (!result_valid && edges < 40) begin
            if (add_load) n_load++;
            if (add_rst_ff) n_rstff++;
            if (add_sipo_load) begin
                n_sipo++;
                if (!prev_sipo) sipo_runs++;
            end
            prev_sipo = add_sipo_load;
            if (!busy) busy_low++;
            if (inject && edges == 3) begin
                start  = 1'b1;
                op_a   = 8'hAA;
                op_b   = 8'h55;
                op_cin = ~v.cin;
            end
            if (inject && edges == 4) start = 1'b0;
            @(posedge clk);
            #1;
            edges++;
        end
        chk("latency",      32'(edges),       32'(WIDTH + 2));
        chk("valid",        32'(result_valid), 32'd1);
        chk("busy_done",    32'(busy),         32'd0);
        chk("sum",          32'(result_sum),   32'(v.sum));
        chk("cout",         32'(result_cout),  32'(v.cout));
        chk("load_cycles",  32'(n_load),       32'd1);
        chk("rstff_cycles", 32'(n_rstff),      32'd1);
        chk("sipo_cycles",  32'(n_sipo),       32'(WIDTH));
        chk("sipo_runs",    32'(sipo_runs),    32'd1);
        chk("busy_gaps",    32'(busy_low),     32'd0);
        if (inject) chk("latched_a", 32'(add_a), 32'(v.a));
    endtask

    task automatic consume();
        result_ready = 1'b1;
        @(posedge clk);
        #1;
        result_ready = 1'b0;
        chk("valid_clear", 32'(result_valid), 32'd0);
        chk("idle_busy",   32'(busy),         32'd0);
    endtask

    initial begin
        vec_t vecs[7];
        vec_t hold_v;
        int   bad;

        vecs[0] = '{a: 8'h3C, b: 8'h0F, cin: 1'b0, sum: 8'h4B, cout: 1'b0};
        vecs[1] = '{a: 8'hFF, b: 8'h01, cin: 1'b0, sum: 8'h00, cout: 1'b1};
        vecs[2] = '{a: 8'hFF, b: 8'hFF, cin: 1'b1, sum: 8'hFF, cout: 1'b1};
        vecs[3] = '{a: 8'h00, b: 8'h00, cin: 1'b0, sum: 8'h00, cout: 1'b0};
        vecs[4] = '{a: 8'hA5, b: 8'h5A, cin: 1'b1, sum: 8'h00, cout: 1'b1};
        vecs[5] = '{a: 8'h12, b: 8'h34, cin: 1'b1, sum: 8'h47, cout: 1'b0};
        vecs[6] = '{a: 8'h7F, b: 8'h01, cin: 1'b0, sum: 8'h80, cout: 1'b0};

        #2 rst_n = 1'b0;
        #1 check_reset_state("rst_async");
        @(posedge clk);
        @(posedge clk);
        #1 check_reset_state("rst_held");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            run_op(vecs[i], 1'b0);
            consume();
        end

        // start pulsed mid-SHIFT must not disturb the running operation
        run_op(vecs[0], 1'b1);
        consume();

        // result must hold while ready is low; ready+start in DONE is not an accept
        hold_v = vecs[5];
        run_op(hold_v, 1'b0);
        bad = 0;
        repeat (5) begin
            @(posedge clk);
            #1;
            if (result_valid !== 1'b1 || result_sum !== hold_v.sum || result_cout !== hold_v.cout) bad++;
        end
        chk("done_hold", 32'(bad), 32'd0);
        result_ready = 1'b1;
        start        = 1'b1;
        op_a         = 8'h55;
        op_b         = 8'h66;
        @(posedge clk);
        #1;
        result_ready = 1'b0;
        start        = 1'b0;
        chk("bubble_valid", 32'(result_valid), 32'd0);
        chk("bubble_busy",  32'(busy),         32'd0);
        @(posedge clk);
        #1;
        chk("bubble_no_accept", 32'(busy),  32'd0);
        chk("bubble_no_load",   32'(add_load), 32'd0);
        chk("bubble_add_a",     32'(add_a), 32'(hold_v.a));

        // reset at SHIFT count 4 aborts with no result
        start  = 1'b1;
        op_a   = 8'h3C;
        op_b   = 8'h0F;
        op_cin = 1'b0;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(posedge clk);
        #1 chk("pre_abort_sipo", 32'(add_sipo_load), 32'd1);
        #1 rst_n = 1'b0;
        #1 check_reset_state("rst_mid_shift");
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        bad = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (result_valid !== 1'b0 || busy !== 1'b0) bad++;
        end
        chk("no_resume_after_abort", 32'(bad), 32'd0);
        run_op(vecs[1], 1'b0);
        consume();

        // start on the first edge after reset release is accepted
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_op(vecs[2], 1'b0);
        consume();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8: operand, sum and shift-count width.
REQ-002 SHALL have port clk  input  1  sole clock, rising-edge active.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  request to add op_a + op_b + op_cin.
REQ-005 SHALL have port op_a  input  WIDTH  operand A, sampled on start acceptance.
REQ-006 SHALL have port op_b  input  WIDTH  operand B, sampled on start acceptance.
REQ-007 SHALL have port op_cin  input  1  carry-in, sampled on start acceptance.
REQ-008 SHALL have port busy  output  1  high from acceptance until result_valid rises.
REQ-009 SHALL have port result_valid  output  1  result_sum/result_cout valid.
REQ-010 SHALL have port result_ready  input  1  consumer accepts result.
REQ-011 SHALL have port result_sum  output  WIDTH  registered sum.
REQ-012 SHALL have port result_cout  output  1  registered carry-out.
REQ-013 SHALL have port add_load  output  1  parallel-load strobe to the serial adder's operand shift registers.
REQ-014 SHALL have port add_rst_shift  output  1  active-high clear to the serial adder's shift registers.
REQ-015 SHALL have port add_rst_ff  output  1  active-high carry flip-flop preset-to-add_cin strobe.
REQ-016 SHALL have port add_sipo_load  output  1  shift-enable to the serial adder's sum SIPO.
REQ-017 SHALL have ports add_a, add_b  output  WIDTH  latched operands; add_cin  output  1  latched carry-in.
REQ-018 SHALL have ports add_sum  input  WIDTH  and add_cout  input  1: serial adder results.

Function
REQ-019 SHALL implement FSM states IDLE, LOAD, SHIFT, CAPTURE, DONE, all registered.
REQ-020 IDLE: start=1 SHALL be accepted on the rising edge, latch op_a/op_b/op_cin into add_a/add_b/add_cin, go to LOAD; start=0 stays IDLE.
REQ-021 start SHALL be ignored in every state other than IDLE; latched operands SHALL not change outside acceptance.
REQ-022 LOAD (exactly 1 cycle): add_load=1, add_rst_ff=1, add_rst_shift=0; clear shift counter to 0; next SHIFT.
REQ-023 SHIFT (exactly WIDTH cycles): add_sipo_load=1; counter increments each edge; at count==WIDTH-1 the module SHALL sample add_cout into an internal carry register and go to CAPTURE.
REQ-024 Counter SHALL be $clog2(WIDTH)+1 bits, SHALL never wrap within one operation.
REQ-025 CAPTURE (1 cycle): register add_sum into result_sum and the sampled carry into result_cout; next DONE.
REQ-026 DONE: result_valid=1, busy=0; result_sum/result_cout SHALL hold stable while result_valid=1 and result_ready=0.
REQ-027 DONE with result_ready=1 SHALL go to IDLE on that edge; start asserted in the same cycle SHALL be ignored (one idle bubble mandatory).
REQ-028 busy SHALL be 1 in LOAD, SHIFT, CAPTURE; 0 in IDLE and DONE.
REQ-029 All strobe outputs (add_load, add_rst_ff, add_sipo_load) SHALL be 0 in every state except where REQ-022/023 assert them; add_rst_shift SHALL be 1 in IDLE only.
REQ-030 Latency: result_valid SHALL rise exactly WIDTH+2 rising edges after the accepting edge (10 for WIDTH=8).
REQ-031 All outputs SHALL be driven from registers or pure state decode; no combinational path from result_ready or start to any output.

Reset
REQ-032 rst_n=0 SHALL asynchronously force IDLE, counter 0, add_a/add_b/add_cin 0, result_sum 0, result_cout 0, result_valid 0, busy 0, add_load/add_rst_ff/add_sipo_load 0, add_rst_shift 1.
REQ-033 Reset asserted in any state, including mid-SHIFT, SHALL abort the operation with no result_valid pulse; operation resumes only via a new start after rst_n=1.
REQ-034 Reset release SHALL take effect on the first rising edge with rst_n=1; start on that edge SHALL be accepted.

Verification
REQ-035 op_a=8'h3C, op_b=8'h0F, op_cin=0, start 1 cycle -> after 10 edges result_valid=1, result_sum=8'h4B, result_cout=0.
REQ-036 op_a=8'hFF, op_b=8'h01, op_cin=0 -> result_sum=8'h00, result_cout=1; op_a=8'hFF, op_b=8'hFF, op_cin=1 -> 8'hFF, cout 1.
REQ-037 start pulsed with new operands during SHIFT -> ignored; result matches the first operands; busy stays 1 through CAPTURE.
REQ-038 result_ready held 0 for 5 cycles in DONE -> result_valid and result fields stable; ready=1 with start=1 same cycle -> IDLE, start not accepted.
REQ-039 rst_n driven 0 at SHIFT count 4 -> all outputs at REQ-032 values immediately, no result_valid; fresh start after release yields correct sum.
REQ-040 Strobe check per operation: add_load and add_rst_ff high exactly 1 cycle, add_sipo_load high exactly WIDTH consecutive cycles.
